// File: rtl/hangman_pkg.sv
// hangman_pkg
// Shared definitions for the inter-board Hangman radio link: the message type
// encoding, the frame layout constants, the default UART bit time, and a
// helper that returns any byte of a frame from its latched payload.
// No ports; imported by msg_tx and uart_tx_byte.
package hangman_pkg;

  // Message kinds carried in the TYPE byte of a frame
  typedef enum logic [1:0] {
    MSG_GUESS       = 2'b00,
    MSG_WORD_LETTER = 2'b01,
    MSG_WORD_DONE   = 2'b10,
    MSG_RESULT      = 2'b11
  } msg_type_t;

  localparam logic [7:0]  SYNC_BYTE            = 8'h7E;
  localparam int unsigned FRAME_BYTES          = 4;
  // 12 MHz system clock / 9600 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;

  // Byte idx of the frame SYNC, TYPE, DATA, CHK; CHK is TYPE xor DATA
  function automatic logic [7:0] frameByte(input logic [1:0] idx,
                                           input msg_type_t  msgType,
                                           input logic [7:0] msgData);
    logic [7:0] typeByte;
    typeByte = {6'b0, msgType};
    case (idx)
      2'd0:    frameByte = SYNC_BYTE;
      2'd1:    frameByte = typeByte;
      2'd2:    frameByte = msgData;
      default: frameByte = typeByte ^ msgData;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Serialises one byte as 8N1: start bit 0, eight data bits LSB first, stop
// bit 1, each held for CLKS_PER_BIT cycles. tx_o is registered.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start_i      load byte_in_i and begin its start bit at this edge
//                (honoured only while ready_o is high)
//   byte_in_i    byte to send
//   tx_o         serial line, idles high
//   done_o       high during the final cycle of the stop bit
//   ready_o      a start this cycle will be accepted
// done_o is combinational so a caller can chain the next byte on the very
// edge the stop bit ends, giving back-to-back bytes with no idle gap.
module uart_tx_byte
  import hangman_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_in_i,
  output logic       tx_o,
  output logic       done_o,
  output logic       ready_o
);

  localparam int unsigned        CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]      LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]         STOP_BIT = 4'd9;

  logic          active_q, active_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [3:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q,  shift_d;
  logic          tx_q,     tx_d;
  logic          lastTick;

  assign lastTick = (cnt_q == LAST_CNT);
  assign done_o   = active_q && lastTick && (bitIdx_q == STOP_BIT);
  assign ready_o  = !active_q || done_o;
  assign tx_o     = tx_q;

  // Bit sequencing: advance the bit index at the end of each bit time and
  // present the next line level; a new start overrides the end of a byte.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (active_q) begin
      if (lastTick) begin
        cnt_d = '0;
        if (bitIdx_q == STOP_BIT) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bitIdx_d = bitIdx_q + 4'd1;
          if (bitIdx_q < 4'd8) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (start_i && ready_o) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bitIdx_d = '0;
      shift_d  = byte_in_i;
      tx_d     = 1'b0;
    end
  end

  // State registers; the line returns to idle-high on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/msg_tx.sv
// msg_tx
// Transmit side of the Hangman radio link. Accepts one game message and
// sends it as the 4-byte frame SYNC, TYPE, DATA, CHK over an 8N1 UART.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   send       request strobe, accepted when busy is low
//   msg_type   message kind (GUESS, WORD_LETTER, WORD_DONE, RESULT)
//   msg_data   payload byte
//   tx         UART serial out, idles high
//   busy       frame in progress
//   msg_sent   one-cycle pulse as a frame completes
//   error      one-cycle pulse for each request dropped while busy
module msg_tx
  import hangman_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [1:0] msg_type,
  input  logic [7:0] msg_data,
  output logic       tx,
  output logic       busy,
  output logic       msg_sent,
  output logic       error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SYNC = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  logic [2:0] state_q,   state_d;
  logic [1:0] byteIdx_q, byteIdx_d;
  msg_type_t  msgType_q, msgType_d;
  logic [7:0] msgData_q, msgData_d;
  logic       busy_q,    busy_d;
  logic       msgSent_q, msgSent_d;
  logic       error_q,   error_d;

  logic       byteStart;
  logic [7:0] byteIn;
  logic       byteTx;
  logic       byteDone;
  logic       byteReady;
  logic [1:0] nextIdx;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .start_i  (byteStart),
    .byte_in_i(byteIn),
    .tx_o     (byteTx),
    .done_o   (byteDone),
    .ready_o  (byteReady)
  );

  // The SYNC byte needs no payload, so it can start on the accepting edge
  // while the latches load; later bytes come from the latched copies.
  assign nextIdx = (state_q == S_IDLE) ? 2'd0 : byteIdx_q + 2'd1;
  assign byteIn  = frameByte(nextIdx, msgType_q, msgData_q);

  assign tx       = byteTx;
  assign busy     = busy_q;
  assign msg_sent = msgSent_q;
  assign error    = error_q;

  // Frame FSM: accept a request when idle, then chain each following byte
  // on the edge the previous stop bit ends.
  always_comb begin
    state_d   = state_q;
    byteIdx_d = byteIdx_q;
    msgType_d = msgType_q;
    msgData_d = msgData_q;
    busy_d    = busy_q;
    msgSent_d = 1'b0;
    error_d   = send && busy_q;
    byteStart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (send && byteReady) begin
          byteStart = 1'b1;
          state_d   = S_SYNC;
          byteIdx_d = 2'd0;
          msgType_d = msg_type_t'(msg_type);
          msgData_d = msg_data;
          busy_d    = 1'b1;
        end
      end
      S_SYNC, S_TYPE, S_DATA: begin
        if (byteDone) begin
          byteStart = 1'b1;
          byteIdx_d = nextIdx;
          state_d   = state_q + 3'd1;
        end
      end
      S_CHK: begin
        if (byteDone && (byteIdx_q == LAST_BYTE)) begin
          state_d   = S_IDLE;
          byteIdx_d = 2'd0;
          busy_d    = 1'b0;
          msgSent_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Registers; reset abandons any partial frame without a pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      byteIdx_q <= '0;
      msgType_q <= MSG_GUESS;
      msgData_q <= '0;
      busy_q    <= 1'b0;
      msgSent_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      byteIdx_q <= byteIdx_d;
      msgType_q <= msgType_d;
      msgData_q <= msgData_d;
      busy_q    <= busy_d;
      msgSent_q <= msgSent_d;
      error_q   <= error_d;
    end
  end

endmodule
